// File: rtl/ifetch_pkg.sv
// Shared fetch-stage definitions: bubble value, opcodes shared with decode,
// fetch mode encoding and the branch offset helper.
package ifetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_HOLD     = 2'd1,
    MODE_REDIRECT = 2'd2
  } ifetch_mode_e;

  // Sign-extended word offset, already scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_next_pc.sv
// Combinational next-pc selection for the fetch stage: branch > jump > stall > pc+4.
module ifetch_next_pc
  import ifetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc4,
  input  logic [15:0] branch_imm,
  input  logic        jump_en,
  input  logic [31:0] jump_pc4,
  input  logic [25:0] jump_index,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic [1:0]  mode
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = branch_pc4 + branch_offset(branch_imm);
  assign jump_target   = {jump_pc4[31:28], jump_index, 2'b00};

  // A redirect beats stall so a stalled wrong-path fetch is still discarded.
  always_comb begin
    next_pc  = pc_plus4;
    redirect = 1'b0;
    mode     = MODE_RUN;
    if (branch_taken) begin
      next_pc  = branch_target;
      redirect = 1'b1;
      mode     = MODE_REDIRECT;
    end else if (jump_en) begin
      next_pc  = jump_target;
      redirect = 1'b1;
      mode     = MODE_REDIRECT;
    end else if (stall) begin
      next_pc = pc;
      mode    = MODE_HOLD;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: pc register and IF/ID pipeline register.
// Optional IFETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc4,
  input  logic [15:0] branch_imm,
  input  logic        jump_en,
  input  logic [31:0] jump_pc4,
  input  logic [25:0] jump_index,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;
  logic [1:0]  mode;

  assign imem_addr = pc;

  ifetch_next_pc u_next_pc (
    .pc           (pc),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_pc4   (branch_pc4),
    .branch_imm   (branch_imm),
    .jump_en      (jump_en),
    .jump_pc4     (jump_pc4),
    .jump_index   (jump_index),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc),
    .redirect     (redirect),
    .mode         (mode)
  );

  // Control contract: stall is a level hold request sampled every edge;
  // branch_taken/jump_en are single-edge redirect pulses that take effect
  // on the edge they are seen, override stall, and insert one bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      pc          <= next_pc;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else if (mode == MODE_RUN) begin
      pc          <= next_pc;
      if_id_instr <= imem_data;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_bubbles <= 32'd0;
    end else if (redirect) begin
      perf_bubbles <= perf_bubbles + 32'd1;
    end else if (mode == MODE_RUN) begin
      perf_fetched <= perf_fetched + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a small memory model.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc4;
  logic [15:0] branch_imm;
  logic        jump_en;
  logic [31:0] jump_pc4;
  logic [25:0] jump_index;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
  logic [31:0] snap_fetched;
  logic [31:0] snap_bubbles;
`endif

  int checks;
  int failures;
  logic [31:0] mem [0:63];
  logic [31:0] exp_q [$];
  logic [31:0] exp_word;

  localparam logic [31:0] W_ADDI1 = 32'h2001_0001;
  localparam logic [31:0] W_ADDI2 = 32'h2002_0002;
  localparam logic [31:0] W_ADD   = 32'h0022_1820;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_pc4   (branch_pc4),
    .branch_imm   (branch_imm),
    .jump_en      (jump_en),
    .jump_pc4     (jump_pc4),
    .jump_index   (jump_index),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
`endif
  );

  // Combinational memory: 256 bytes, zero when unaligned or out of range.
  assign imem_data = (imem_addr[1:0] == 2'b00 && imem_addr < 32'd256) ?
                     mem[imem_addr[7:2]] : 32'd0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic drive_idle();
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_pc4   = 32'd0;
    branch_imm   = 16'd0;
    jump_en      = 1'b0;
    jump_pc4     = 32'd0;
    jump_index   = 26'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input logic [31:0] pc4,
                            input logic valid);
    check({tag, "_pc"}, imem_addr, pc);
    check({tag, "_instr"}, if_id_instr, instr);
    check({tag, "_pc4"}, if_id_pc4, pc4);
    check({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h2400_0000 | i;
    mem[0] = W_ADDI1;
    mem[1] = W_ADDI2;
    mem[2] = W_ADD;
    drive_idle();

    // reset state, checked before any edge
    rst_n = 1'b0;
    #3;
    check_ifid("reset", 32'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // in-order fetch after release
    exp_q.push_back(W_ADDI1);
    exp_q.push_back(W_ADDI2);
    step();
    exp_word = exp_q.pop_front();
    check_ifid("fetch0", 32'd4, exp_word, 32'd4, 1'b1);
    step();
    exp_word = exp_q.pop_front();
    check_ifid("fetch1", 32'd8, exp_word, 32'd8, 1'b1);

    // stall three edges at pc=8
`ifdef IFETCH_PERF_CNT_EN
    snap_fetched = perf_fetched;
`endif
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("stall", 32'd8, W_ADDI2, 32'd8, 1'b1);
    end
`ifdef IFETCH_PERF_CNT_EN
    check("perf_fetched_hold", perf_fetched, snap_fetched);
`endif
    stall = 1'b0;
    step();
    check_ifid("resume", 32'd12, W_ADD, 32'd12, 1'b1);
    step();
    step();
    step();
    check_ifid("run24", 32'd24, mem[5], 32'd24, 1'b1);

    // jump at pc=24 to 24 (wrong path discarded)
    jump_en = 1'b1; jump_pc4 = 32'd20; jump_index = 26'd6;
    step();
    drive_idle();
    check_ifid("jump_bubble", 32'd24, 32'd0, 32'd0, 1'b0);
    step();
    check_ifid("jump_target", 32'd28, mem[6], 32'd28, 1'b1);

    // backward branch 28 - 12 = 16
    branch_taken = 1'b1; branch_pc4 = 32'd28; branch_imm = 16'hFFFD;
    step();
    drive_idle();
    check_ifid("br_bubble", 32'd16, 32'd0, 32'd0, 1'b0);
    step();
    check_ifid("br_target", 32'd20, mem[4], 32'd20, 1'b1);

    // branch + jump + stall together: branch to 44+4=48 wins
`ifdef IFETCH_PERF_CNT_EN
    snap_bubbles = perf_bubbles;
    snap_fetched = perf_fetched;
`endif
    branch_taken = 1'b1; branch_pc4 = 32'd44; branch_imm = 16'h0001;
    jump_en = 1'b1; jump_pc4 = 32'd0; jump_index = 26'd3;
    stall = 1'b1;
    step();
    drive_idle();
    check_ifid("prio_bubble", 32'd48, 32'd0, 32'd0, 1'b0);
`ifdef IFETCH_PERF_CNT_EN
    check("perf_bubbles_inc", perf_bubbles, snap_bubbles + 32'd1);
    check("perf_fetched_redir", perf_fetched, snap_fetched);
`endif
    step();
    check_ifid("prio_target", 32'd52, mem[12], 32'd52, 1'b1);

    // wrap: branch to 0xFFFFFFFC, pc+4 wraps to 0
    branch_taken = 1'b1; branch_pc4 = 32'd0; branch_imm = 16'hFFFF;
    step();
    drive_idle();
    check_ifid("wrap_bubble", 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0);
    step();
    check_ifid("wrap_fetch", 32'd0, 32'd0, 32'd0, 1'b1);
    step();
    check_ifid("wrap_next", 32'd4, W_ADDI1, 32'd4, 1'b1);

    // jump to 40, run one edge, then asynchronous reset mid-cycle
    jump_en = 1'b1; jump_pc4 = 32'd0; jump_index = 26'd10;
    step();
    drive_idle();
    check_ifid("jump40", 32'd40, 32'd0, 32'd0, 1'b0);
    step();
    check_ifid("run44", 32'd44, mem[10], 32'd44, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_ifid("async_rst", 32'd0, 32'd0, 32'd0, 1'b0);
`ifdef IFETCH_PERF_CNT_EN
    check("perf_rst_f", perf_fetched, 32'd0);
    check("perf_rst_b", perf_bubbles, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_ifid("post_rst", 32'd4, W_ADDI1, 32'd4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
